col_hit_reader: RTL and testbench

COL_HIT_READER -- requirements
Module: col_hit_reader

---
 rtl/col_hit_reader.sv | 171 +++++++++++++++++
 tb/tb_col_hit_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/col_hit_reader.sv
// col_hit_reader: drains one event's hits from the head of a column chain into
// a small output FIFO.
//
// Sequence: startRead -> LATCH (sample the pending-hit count, capped at
// MAXHITS) -> FETCH (pop the chain at most once every two cycles while the
// FIFO has room) -> DONE (one-cycle colDone pulse) -> IDLE.
//
// Ports
//   clk, rstn           single clock; asynchronous active-low reset
//   startRead           one-cycle request to read the current event
//   dnHits, dnData      pending-hit count and head word of the column chain
//   dnRead              one-cycle pop strobe to the chain
//   outData/outParity   registered FIFO head word and its parity
//   outValid/outReady   output handshake; a word moves when both are 1
//   busy                event in progress (LATCH, FETCH or DONE)
//   colDone, hitCount   completion pulse and number of words fetched
//   startErr            sticky flag: startRead seen while not idle
//
// Build option: define COL_READ_PARITY_EN to store even parity per FIFO entry
// and present it on outParity; otherwise outParity is tied to 0.
module col_hit_reader #(
  parameter int FIFODEPTH = 4,
  parameter int MAXHITS   = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        startRead,
  input  logic [4:0]  dnHits,
  input  logic [45:0] dnData,
  output logic        dnRead,
  output logic [45:0] outData,
  output logic        outParity,
  output logic        outValid,
  input  logic        outReady,
  output logic        busy,
  output logic        colDone,
  output logic [4:0]  hitCount,
  output logic        startErr
);

  localparam int PW = $clog2(FIFODEPTH);
`ifdef COL_READ_PARITY_EN
  localparam int EW = 47;
`else
  localparam int EW = 46;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, LATCH = 2'd1, FETCH = 2'd2, DONE = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [4:0]    rem_q, rem_d;
  logic [4:0]    fetched_q, fetched_d;
  logic [4:0]    hit_count_q, hit_count_d;
  logic          popped_q, popped_d;
  logic          start_err_q, start_err_d;
  logic          rdy_q;
  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0] mem_q [FIFODEPTH];
  logic [EW-1:0] mem_d [FIFODEPTH];
  logic          out_valid_q, out_valid_d;
  logic [EW-1:0] out_word_q, out_word_d;
  logic [EW-1:0] wr_word;
  logic          fifo_full, fifo_wr, fifo_rd;

`ifdef COL_READ_PARITY_EN
  assign wr_word = {^dnData, dnData};
`else
  assign wr_word = dnData;
`endif

  // Same slot index with differing wrap bits means full.
  assign fifo_full = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // Control FSM: next state, counters and the pop strobe.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    fetched_d   = fetched_q;
    hit_count_d = hit_count_q;
    start_err_d = start_err_q;
    dnRead      = 1'b0;
    if (startRead && state_q != IDLE) start_err_d = 1'b1;
    case (state_q)
      IDLE: begin
        // rdy_q masks the first edge after reset release.
        if (startRead && rdy_q) begin
          state_d   = LATCH;
          fetched_d = '0;
        end
      end
      LATCH: begin
        rem_d   = (int'(dnHits) > MAXHITS) ? 5'(MAXHITS) : dnHits;
        state_d = (rem_d == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end else if (!fifo_full && !popped_q) begin
          // popped_q spaces pops two cycles apart so the chain can advance.
          dnRead    = 1'b1;
          rem_d     = rem_q - 5'd1;
          fetched_d = fetched_q + 5'd1;
          if (rem_q == 5'd1) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Load on DONE entry so hitCount is already valid alongside colDone.
    if (state_d == DONE && state_q != DONE) hit_count_d = fetched_d;
  end

  assign popped_d = dnRead;

  // Output FIFO. The head word is re-registered each cycle from the updated
  // storage, so a write into an empty FIFO appears on outData one cycle later.
  always_comb begin
    fifo_wr  = dnRead;
    fifo_rd  = out_valid_q & outReady;
    wr_ptr_d = wr_ptr_q + (PW+1)'(fifo_wr);
    rd_ptr_d = rd_ptr_q + (PW+1)'(fifo_rd);
    mem_d    = mem_q;
    if (fifo_wr) mem_d[wr_ptr_q[PW-1:0]] = wr_word;
    out_valid_d = (wr_ptr_d != rd_ptr_d);
    out_word_d  = mem_d[rd_ptr_d[PW-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      fetched_q   <= '0;
      hit_count_q <= '0;
      popped_q    <= 1'b0;
      start_err_q <= 1'b0;
      rdy_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      fetched_q   <= fetched_d;
      hit_count_q <= hit_count_d;
      popped_q    <= popped_d;
      start_err_q <= start_err_d;
      rdy_q       <= 1'b1;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
    end
  end

  assign outData  = out_word_q[45:0];
`ifdef COL_READ_PARITY_EN
  assign outParity = out_word_q[46];
`else
  assign outParity = 1'b0;
`endif
  assign outValid = out_valid_q;
  assign busy     = (state_q != IDLE);
  assign colDone  = (state_q == DONE);
  assign hitCount = hit_count_q;
  assign startErr = start_err_q;

endmodule

// File: tb/tb_col_hit_reader.sv
`timescale 1ns/100ps
module tb_col_hit_reader;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        startRead = 1'b0;
  logic        outReady = 1'b0;
  logic [4:0]  dnHits;
  logic [45:0] dnData;
  logic        dnRead, outParity, outValid, busy, colDone, startErr;
  logic [45:0] outData;
  logic [4:0]  hitCount;

  // Column chain model: words appended at tail, popped at head on dnRead.
  logic [45:0] chain_mem [64];
  int head = 0, tail = 0, exp_head = 0;

  logic [45:0] exp_q [$];
  int pop_cyc [$];
  int cyc = 0, dones = 0;
  int n_chk = 0, n_fail = 0;

  always #12.5 clk = ~clk;

  always @(posedge clk) if (dnRead) head <= head + 1;
  assign dnHits = ((tail - head) > 31) ? 5'd31 : 5'(tail - head);
  assign dnData = chain_mem[head[5:0]];

  col_hit_reader dut (
    .clk(clk), .rstn(rstn), .startRead(startRead), .dnHits(dnHits),
    .dnData(dnData), .dnRead(dnRead), .outData(outData), .outParity(outParity),
    .outValid(outValid), .outReady(outReady), .busy(busy), .colDone(colDone),
    .hitCount(hitCount), .startErr(startErr)
  );

  function automatic logic [45:0] mkw(int k);
    return {14'(k * 37 + 5), 32'(32'hC3A5_0F00 ^ (k * 32'h0101_0103))};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_pulse();
    startRead = 1'b1;
    tick();
    startRead = 1'b0;
  endtask

  task automatic add_words(int n);
    for (int i = 0; i < n; i++) begin
      chain_mem[tail[5:0]] = mkw(tail);
      tail++;
    end
  endtask

  // Push the words the DUT should deliver for this event.
  task automatic expect_n(int n);
    for (int i = 0; i < n; i++) exp_q.push_back(chain_mem[(exp_head + i) % 64]);
    exp_head += n;
  endtask

  task automatic wait_done(string name, int budget);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clk); #1;
      if (colDone) break;
      k++;
    end
    chk(name, colDone, 1);
  endtask

  task automatic wait_pops(string name, int n, int p0, int budget);
    int k;
    k = 0;
    while (k < budget && (pop_cyc.size() - p0) < n) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, (pop_cyc.size() - p0) >= n, 1);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_dnRead"},    dnRead,    0);
    chk({tag, "_outValid"},  outValid,  0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_colDone"},   colDone,   0);
    chk({tag, "_startErr"},  startErr,  0);
    chk({tag, "_outParity"}, outParity, 0);
    chk({tag, "_outData"},   outData,   0);
    chk({tag, "_hitCount"},  hitCount,  0);
  endtask

  initial begin
    int p0, d0;
    for (int i = 0; i < 64; i++) chain_mem[i] = '0;

    // Scoreboard monitor: counts pops/done pulses and checks every transfer.
    fork
      forever begin
        logic [45:0] w;
        @(negedge clk);
        cyc++;
        if (rstn) begin
          if (dnRead) pop_cyc.push_back(cyc);
          if (colDone) dones++;
          if (outValid && outReady) begin
            if (exp_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL out_unexpected: got 0x%0h, expected no word", outData);
            end else begin
              w = exp_q.pop_front();
              chk("out_data", outData, w);
`ifdef COL_READ_PARITY_EN
              chk("out_parity", outParity, ^w);
`else
              chk("out_parity", outParity, 0);
`endif
            end
          end
        end
      end
    join_none

    // Reset state
    #5 rstn = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    tick();

    // 3 hits, ready downstream: pops two cycles apart, words in order
    add_words(3);
    expect_n(3);
    outReady = 1'b1;
    p0 = pop_cyc.size();
    start_pulse();
    wait_done("t1_done", 40);
    chk("t1_hitCount", hitCount, 3);
    chk("t1_pops", pop_cyc.size() - p0, 3);
    if (pop_cyc.size() - p0 >= 3) begin
      chk("t1_gap1", pop_cyc[p0 + 1] - pop_cyc[p0], 2);
      chk("t1_gap2", pop_cyc[p0 + 2] - pop_cyc[p0 + 1], 2);
    end
    repeat (4) tick();
    chk("t1_drain", exp_q.size(), 0);

    // Zero hits: colDone two cycles after startRead, nothing fetched
    p0 = pop_cyc.size();
    start_pulse();
    @(negedge clk); #1;
    chk("t2_latch_colDone", colDone, 0);
    chk("t2_latch_busy", busy, 1);
    @(negedge clk); #1;
    chk("t2_colDone", colDone, 1);
    chk("t2_hitCount", hitCount, 0);
    chk("t2_outValid", outValid, 0);
    chk("t2_pops", pop_cyc.size() - p0, 0);
    tick();

    // 8 hits into a 4-deep FIFO with downstream stalled
    add_words(8);
    expect_n(8);
    outReady = 1'b0;
    p0 = pop_cyc.size();
    start_pulse();
    repeat (20) tick();
    chk("t3_stall_pops", pop_cyc.size() - p0, 4);
    chk("t3_stall_dnRead", dnRead, 0);
    chk("t3_stall_outValid", outValid, 1);
    chk("t3_stall_busy", busy, 1);
    outReady = 1'b1;
    wait_done("t3_done", 80);
    chk("t3_hitCount", hitCount, 8);
    chk("t3_pops", pop_cyc.size() - p0, 8);
    repeat (4) tick();
    chk("t3_drain", exp_q.size(), 0);

    // 20 pending hits: capped at 16
    add_words(20);
    expect_n(16);
    p0 = pop_cyc.size();
    start_pulse();
    wait_done("t4_done", 100);
    chk("t4_hitCount", hitCount, 16);
    chk("t4_pops", pop_cyc.size() - p0, 16);
    repeat (4) tick();
    chk("t4_drain", exp_q.size(), 0);

    // startRead during FETCH: flagged, ignored, event completes
    add_words(1);
    expect_n(5);
    p0 = pop_cyc.size();
    start_pulse();
    wait_pops("t5_first_pop", 1, p0, 20);
    start_pulse();
    chk("t5_startErr", startErr, 1);
    wait_done("t5_done", 60);
    chk("t5_hitCount", hitCount, 5);
    repeat (4) tick();
    chk("t5_idle_busy", busy, 0);
    chk("t5_startErr_held", startErr, 1);
    chk("t5_pops", pop_cyc.size() - p0, 5);
    chk("t5_drain", exp_q.size(), 0);

    // Reset after 2 of 5 pops: everything cleared, no colDone, chain not rewound
    add_words(5);
    outReady = 1'b0;
    p0 = pop_cyc.size();
    d0 = dones;
    start_pulse();
    wait_pops("t6_two_pops", 2, p0, 20);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1 chk_all_zero("t6_rst");
    exp_head += 2;
    repeat (3) tick();
    rstn = 1'b1;
    startRead = 1'b1;   // sampled on the first edge after release: ignored
    tick();
    startRead = 1'b0;
    @(negedge clk); #1;
    chk("t6_first_edge_ignored", busy, 0);
    chk("t6_first_edge_noerr", startErr, 0);
    chk("t6_no_colDone", dones - d0, 0);
    expect_n(3);
    outReady = 1'b1;
    start_pulse();
    wait_done("t6_done", 40);
    chk("t6_hitCount", hitCount, 3);
    repeat (4) tick();
    chk("t6_one_colDone", dones - d0, 1);
    chk("t6_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
